// File: rtl/pc_unit.sv
// Fetch-stage program counter with next-PC selection.
// Redirect sources are exceptions, exception return, branch and jump.
// A branch or jump that arrives during a stall is held in a one-entry
// pending register and is applied on the first unstalled cycle.
// adel_f flags a misaligned or out-of-range fetch address.
module pc_unit #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0]      EXC_VEC   = 32'h0000_4180,
  parameter logic [WIDTH-1:0]      IM_BASE   = 32'h0000_3000,
  parameter logic [WIDTH-1:0]      IM_SIZE   = 32'h0000_4000,
  parameter logic [WIDTH-1:0]      STEP      = 32'd4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc_f,
  output logic [WIDTH-1:0] pc_plus,
  output logic             adel_f,
  output logic             pend_valid
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  // Bounds are evaluated one bit wider so IM_BASE + IM_SIZE cannot wrap.
  localparam logic [WIDTH:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [WIDTH:0] IM_HI = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

  logic [WIDTH:0] pc_ext;
  logic           misaligned;
  logic           out_of_range;

  // Sequential increment wraps modulo 2^WIDTH.
  assign pc_plus = pc_q + STEP;

  // Next-PC priority: exception, eret, branch, jump, pending, step, hold.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned, which would infer a latch.
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_tgt_d   = pend_tgt_q;

    if (exc_req) begin
      pc_d         = EXC_VEC;
      pend_valid_d = 1'b0;
    end else if (eret) begin
      pc_d         = epc;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      // PC holds; a branch or jump is parked, newest one overwriting.
      if (br_taken) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = br_target;
      end else if (jump) begin
        pend_valid_d = 1'b1;
        pend_tgt_d   = jump_target;
      end
    end else if (br_taken) begin
      pc_d         = br_target;
      pend_valid_d = 1'b0;
    end else if (jump) begin
      pc_d         = jump_target;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      pc_d         = pend_tgt_q;
      pend_valid_d = 1'b0;
    end else begin
      pc_d = pc_plus;
    end
  end

  // State registers with synchronous, active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (reset) begin
      pc_q         <= RESET_VEC;
      pend_valid_q <= 1'b0;
      // NOTE: the pending target is reset too, so no X can ever reach pc_f even though pend_valid already guards it.
      pend_tgt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_tgt_q   <= pend_tgt_d;
    end
  end

  // Fetch address error: misaligned word or outside instruction memory.
  always_comb begin
    pc_ext       = {1'b0, pc_q};
    misaligned   = (pc_q[1:0] != 2'b00);
    out_of_range = (pc_ext < IM_LO) || (pc_ext >= IM_HI);
    adel_f       = misaligned || out_of_range;
  end

  assign pc_f       = pc_q;
  assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with hand-computed expected values.
module tb_pc_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         br_taken;
  logic [W-1:0] br_target;
  logic         jump;
  logic [W-1:0] jump_target;
  logic         exc_req;
  logic         eret;
  logic [W-1:0] epc;
  logic [W-1:0] pc_f;
  logic [W-1:0] pc_plus;
  logic         adel_f;
  logic         pend_valid;

  int checks   = 0;
  int failures = 0;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .pc_f        (pc_f),
    .pc_plus     (pc_plus),
    .adel_f      (adel_f),
    .pend_valid  (pend_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jump = 0; exc_req = 0; eret = 0;
  endtask

  initial begin
    reset = 1; idle();
    br_target = '0; jump_target = '0; epc = '0;
    step();
    reset = 0;
    check("rst_pc", pc_f, 32'h3000);
    check("rst_pend", W'(pend_valid), 0);
    check("rst_adel", W'(adel_f), 0);
    check("rst_plus", pc_plus, 32'h3004);

    // Free-running sequence.
    step(); check("seq1", pc_f, 32'h3004);
    step(); check("seq2", pc_f, 32'h3008);
    step(); check("seq3", pc_f, 32'h300C);
    check("seq_adel", W'(adel_f), 0);
    step(); check("seq4", pc_f, 32'h3010);

    // Branch captured during a 2-cycle stall.
    stall = 1; br_taken = 1; br_target = 32'h3100;
    step(); check("stb_pc0", pc_f, 32'h3010); check("stb_pend0", W'(pend_valid), 1);
    br_taken = 0;
    step(); check("stb_pc1", pc_f, 32'h3010); check("stb_pend1", W'(pend_valid), 1);
    stall = 0;
    step(); check("stb_apply", pc_f, 32'h3100); check("stb_pend2", W'(pend_valid), 0);
    step(); check("stb_next", pc_f, 32'h3104);

    // Last stalled redirect wins.
    stall = 1; jump = 1; jump_target = 32'h3200;
    step(); check("lw_hold0", pc_f, 32'h3104); check("lw_pend0", W'(pend_valid), 1);
    jump = 0; br_taken = 1; br_target = 32'h3300;
    step(); check("lw_hold1", pc_f, 32'h3104);
    idle();
    step(); check("lw_apply", pc_f, 32'h3300); check("lw_pend", W'(pend_valid), 0);
    step(); check("lw_next", pc_f, 32'h3304);

    // Exception during stall with pending redirect, then eret.
    stall = 1; jump = 1; jump_target = 32'h3500;
    step(); check("exc_pend0", W'(pend_valid), 1);
    jump = 0; exc_req = 1;
    step(); check("exc_pc", pc_f, 32'h4180); check("exc_pend", W'(pend_valid), 0);
    check("exc_adel", W'(adel_f), 0);
    idle(); eret = 1; epc = 32'h3020;
    step(); check("eret_pc", pc_f, 32'h3020);
    // exc_req beats eret.
    exc_req = 1; eret = 1; epc = 32'h3060;
    step(); check("exc_eret", pc_f, 32'h4180);
    // eret ignores stall.
    idle(); stall = 1; eret = 1; epc = 32'h3024;
    step(); check("eret_stall", pc_f, 32'h3024);

    // Address error boundaries.
    idle(); jump = 1; jump_target = 32'h3002;
    step(); check("mis_pc", pc_f, 32'h3002); check("mis_adel", W'(adel_f), 1);
    jump_target = 32'h7000;
    step(); check("hi_adel", W'(adel_f), 1);
    jump_target = 32'h6FFC;
    step(); check("top_pc", pc_f, 32'h6FFC); check("top_adel", W'(adel_f), 0);
    jump = 0;
    step(); check("top_step", pc_f, 32'h7000); check("top_step_adel", W'(adel_f), 1);
    jump = 1; jump_target = 32'h2FFC;
    step(); check("lo_adel", W'(adel_f), 1);

    // Branch beats jump.
    br_taken = 1; br_target = 32'h3040; jump = 1; jump_target = 32'h3080;
    step(); check("br_jmp", pc_f, 32'h3040);

    // Reset with a pending redirect discards it.
    idle(); stall = 1; br_taken = 1; br_target = 32'h3100;
    step(); check("rp_pend", W'(pend_valid), 1);
    reset = 1;
    step(); check("rp_pc", pc_f, 32'h3000); check("rp_pend0", W'(pend_valid), 0);
    reset = 0; idle();
    step(); check("rp_next", pc_f, 32'h3004);

    // Modulo wrap.
    jump = 1; jump_target = 32'hFFFF_FFFC;
    step(); check("wr_plus", pc_plus, 32'h0); check("wr_adel", W'(adel_f), 1);
    jump = 0;
    step(); check("wr_pc", pc_f, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
